// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of the instruction decoder. It holds the
// program counter, addresses program memory (combinational read) and registers
// the returned word into the instruction register (IR). The decoder answers
// with pc_mux / pc_save / int_mux, which select the next PC, drive the
// hardware return-address stack and trigger interrupt entry.
//
// Build option:
//   FETCH_IRQ_EN  defined   -> irq synchronizer, pending latch, global
//                              interrupt enable and interrupt entry present.
//                 undefined -> o_interrupt tied low; i_irq, i_gie_set and
//                              i_int_mux are ignored.
//
// Ports:
//   i_clk               rising-edge clock
//   i_rst_n             asynchronous active-low reset
//   o_pc                program memory address (registered)
//   i_instr_rdata       program memory word at o_pc, same cycle
//   o_opcode            IR[13:9] (instruction + dest bit) to decoder
//   o_operand           IR[8:0]
//   i_branch_target     jump/call target from operand path
//   i_pc_mux            00 pc+1, 01 branch_target, 10 pop stack, 11 pc+2
//   i_pc_save           push o_pc as return address this cycle
//   i_int_mux           decoder accepts the interrupt
//   i_stall             freeze PC, IR, stack and gie
//   i_irq               asynchronous level interrupt request
//   i_gie_set           set global interrupt enable
//   o_interrupt         interrupt request towards the decoder
//   o_stack_overflow    sticky: push while stack full
//   o_stack_underflow   sticky: pop while stack empty
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int                     PC_WIDTH     = 12,
   parameter int                     INSTR_WIDTH  = 14,
   parameter int                     STACK_DEPTH  = 8,
   parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = 12'h000,
   parameter logic [PC_WIDTH-1:0]    INT_VECTOR   = 12'h004,
   parameter logic [INSTR_WIDTH-1:0] NOP_WORD     = 14'h0000
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   output logic [PC_WIDTH-1:0]    o_pc,
   input  logic [INSTR_WIDTH-1:0] i_instr_rdata,
   output logic [4:0]             o_opcode,
   output logic [8:0]             o_operand,
   input  logic [PC_WIDTH-1:0]    i_branch_target,
   input  logic [1:0]             i_pc_mux,
   input  logic                   i_pc_save,
   input  logic                   i_int_mux,
   input  logic                   i_stall,
   input  logic                   i_irq,
   input  logic                   i_gie_set,
   output logic                   o_interrupt,
   output logic                   o_stack_overflow,
   output logic                   o_stack_underflow
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam int SP_W  = IDX_W + 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   localparam logic [1:0] MUX_INC  = 2'b00;
   localparam logic [1:0] MUX_BR   = 2'b01;
   localparam logic [1:0] MUX_POP  = 2'b10;
   localparam logic [1:0] MUX_SKIP = 2'b11;

   // fetch / decode state
   logic [PC_WIDTH-1:0]    r_pc;
   logic [INSTR_WIDTH-1:0] r_ir;
   logic                   r_ir_valid;

   // return-address stack: r_top is the next write slot, r_sp the fill count
   logic [PC_WIDTH-1:0]    r_stack [STACK_DEPTH];
   logic [IDX_W-1:0]       r_top;
   logic [SP_W-1:0]        r_sp;
   logic                   r_ovf;
   logic                   r_unf;

   logic                   w_take_int;
   logic                   w_stack_empty;
   logic [IDX_W-1:0]       w_top_m1;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_flush;
   logic [PC_WIDTH-1:0]    w_pc_next;

   assign w_stack_empty = (r_sp == '0);
   assign w_top_m1      = r_top - IDX_W'(1);

   // ------------------------------------------------------------------------
   // Interrupt front end
   // ------------------------------------------------------------------------
`ifdef FETCH_IRQ_EN
   logic r_irq_s1;
   logic r_irq_s2;
   logic r_irq_s3;
   logic r_pending;
   logic r_gie;

   assign w_take_int = i_int_mux;

   // The synchronizer and pending latch keep running through a stall so a
   // request arriving while frozen is not lost.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_irq_s1  <= 1'b0;
         r_irq_s2  <= 1'b0;
         r_irq_s3  <= 1'b0;
         r_pending <= 1'b0;
         r_gie     <= 1'b0;
      end else begin
         r_irq_s1 <= i_irq;
         r_irq_s2 <= r_irq_s1;
         r_irq_s3 <= r_irq_s2;
         // a fresh edge wins over the clear from an interrupt being taken
         if (r_irq_s2 && !r_irq_s3) begin
            r_pending <= 1'b1;
         end else if (!i_stall && w_take_int) begin
            r_pending <= 1'b0;
         end
         if (!i_stall) begin
            if (w_take_int) begin
               r_gie <= 1'b0;
            end else if (i_gie_set) begin
               r_gie <= 1'b1;
            end
         end
      end
   end

   // Built from registered state and stall only; nothing from the decoder's
   // answer loops back into this request.
   assign o_interrupt = r_pending & r_gie & r_ir_valid & ~i_stall;
`else
   logic w_unused_irq;

   assign w_take_int   = 1'b0;
   assign o_interrupt  = 1'b0;
   assign w_unused_irq = ^{i_irq, i_gie_set, i_int_mux, r_ir_valid};
`endif

   // ------------------------------------------------------------------------
   // Next-PC selection and stack control
   // ------------------------------------------------------------------------
   always_comb begin
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_pc_next = r_pc + PC_WIDTH'(1);
      w_flush   = (i_pc_mux != MUX_INC) | w_take_int;

      if (w_take_int) begin
         w_push    = 1'b1;
         w_pc_next = INT_VECTOR;
      end else begin
         case (i_pc_mux)
            MUX_POP: begin
               w_pop     = 1'b1;
               w_pc_next = w_stack_empty ? RESET_VECTOR : r_stack[w_top_m1];
            end
            MUX_BR:   w_pc_next = i_branch_target;
            MUX_SKIP: w_pc_next = r_pc + PC_WIDTH'(2);
            default:  w_pc_next = r_pc + PC_WIDTH'(1);
         endcase
         // a save request alongside a return is dropped: pop only
         if (i_pc_save && (i_pc_mux != MUX_POP)) begin
            w_push = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // PC and instruction register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc       <= RESET_VECTOR;
         r_ir       <= NOP_WORD;
         r_ir_valid <= 1'b0;
      end else if (!i_stall) begin
         r_pc <= w_pc_next;
         // any redirect squashes the word fetched down the wrong path
         if (w_flush) begin
            r_ir       <= NOP_WORD;
            r_ir_valid <= 1'b0;
         end else begin
            r_ir       <= i_instr_rdata;
            r_ir_valid <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Return-address stack (circular)
   // ------------------------------------------------------------------------
   // When full, the write slot r_top coincides with the oldest entry, so a
   // push simply overwrites it and the count stays saturated.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_top <= '0;
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            r_stack[i] <= RESET_VECTOR;
         end
      end else if (!i_stall) begin
         if (w_push) begin
            r_stack[r_top] <= r_pc;
            r_top          <= r_top + IDX_W'(1);
            if (r_sp == SP_FULL) begin
               r_ovf <= 1'b1;
            end else begin
               r_sp <= r_sp + SP_W'(1);
            end
         end else if (w_pop) begin
            if (w_stack_empty) begin
               r_unf <= 1'b1;
            end else begin
               r_top <= w_top_m1;
               r_sp  <= r_sp - SP_W'(1);
            end
         end
      end
   end

   assign o_pc              = r_pc;
   assign o_opcode          = r_ir[13:9];
   assign o_operand         = r_ir[8:0];
   assign o_stack_overflow  = r_ovf;
   assign o_stack_underflow = r_unf;

endmodule
